lsu_ctrl: RTL and testbench

Load/store controller between the CPU datapath and the 1 KB byte-addressed data memory `dm_1k`.
- Accepts one memory request at a time: byte, halfword or word; load or store; signed or unsigned loads.
- Sequences word-aligned memory accesses with an FSM.
- Byte and halfword stores use read-modify-write.
- Flags misaligned requests without touching memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 42 ++++
 rtl/lsu_ctrl.sv | 107 ++++++++++
 tb/tb_lsu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller:
// size codes, FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // The reserved size code is rejected the same way as a bad alignment.
  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic m;
    case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = lo[0];
      SZ_W:    m = |lo;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: load extraction/extension
// and store merge into a little-endian 32-bit word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a_lo,
  input  logic        sign_ext,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  bsel;

  always_comb begin
    bsel     = {a_lo, 3'b000};
    byte_v   = word_in[bsel +: 8];
    half_v   = a_lo[1] ? word_in[31:16] : word_in[15:0];
    load_val = word_in;
    merged   = word_in;
    case (size)
      SZ_B: begin
        load_val = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged[bsel +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_val = {{16{sign_ext & half_v[15]}}, half_v};
        if (a_lo[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      SZ_W: begin
        merged = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM: one request at a time,
// word-aligned accesses, read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        size_q;
  logic              st_q;
  logic              sext_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_buf_q;
  logic [31:0]       rdata_q;

  logic [31:0] word_in;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

  // Upper CPU address bits wrap away.
  assign unused_addr = ^addr[31:ADDR_W];

  // Loads extract straight from memory in RD; stores merge the buffered word.
  assign word_in = (state_q == S_RD) ? dm_dout : word_buf_q;

  lsu_lane u_lane (
    .size     (size_q),
    .a_lo     (a_q[1:0]),
    .sign_ext (sext_q),
    .word_in  (word_in),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (misaligned(size, addr[1:0])) state_d = S_ERR;
          else                             state_d = S_RD;
        end
      end
      S_RD:    state_d = st_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      size_q     <= SZ_B;
      st_q       <= 1'b0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      word_buf_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req) begin
        a_q     <= addr[ADDR_W-1:0];
        size_q  <= size;
        st_q    <= is_store;
        sext_q  <= sign_ext;
        wdata_q <= wdata;
      end
      if (state_q == S_RD) begin
        word_buf_q <= dm_dout;
        if (!st_q) rdata_q <= load_val;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign misalign = (state_q == S_ERR);
  assign dm_we    = (state_q == S_WR);
  assign dm_addr  = {a_q[ADDR_W-1:2], 2'b00};
  assign dm_din   = merged;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a behavioural
// 1 KB word memory and hand-computed directed vectors.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;
  logic        mem_clr = 1'b1;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .is_store (is_store),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .rdata    (rdata),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .dm_dout  (dm_dout)
  );

  assign dm_dout = mem[dm_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (dm_we) begin
      mem[dm_addr[9:2]] <= dm_din;
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] ad;
    logic [31:0] wd;
    int          lat;
    logic        mis;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [25];

  function automatic vec_t mk(input logic st, input logic [1:0] sz,
                              input logic sx, input logic [31:0] ad,
                              input logic [31:0] wd, input int lat,
                              input logic mis, input logic [31:0] rd);
    vec_t v;
    v.st = st; v.sz = sz; v.sx = sx; v.ad = ad; v.wd = wd;
    v.lat = lat; v.mis = mis; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    is_store = v.st;
    size     = v.sz;
    sign_ext = v.sx;
    addr     = v.ad;
    wdata    = v.wd;
  endtask

  task automatic run_req(input vec_t v, output int lat, output logic mis,
                         output int nwe, output int wecyc, output logic bsy);
    @(negedge clk);
    drive(v);
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; mis = 1'b0; nwe = 0; wecyc = -1; bsy = 1'b0;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      if (dm_we) begin
        nwe++;
        wecyc = c;
        chk("dm_addr low bits", 32'(dm_addr[1:0]), 32'd0);
      end
      if (done) begin
        lat = c;
        mis = misalign;
        bsy = busy;
      end
    end
  endtask

  task automatic run_chk(input string nm, input vec_t v);
    int   lat, nwe, wecyc;
    logic mis, bsy;
    run_req(v, lat, mis, nwe, wecyc, bsy);
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " misalign"}, 32'(mis), 32'(v.mis));
    chk({nm, " rdata"}, rdata, v.rd);
    chk({nm, " busy@done"}, 32'(bsy), 32'd1);
    chk({nm, " we count"}, 32'(nwe), (v.st && !v.mis) ? 32'd1 : 32'd0);
    if (v.st && !v.mis) chk({nm, " we cycle"}, 32'(wecyc), 32'd2);
  endtask

  initial begin
    int dcnt;
    tv[0]  = mk(1, 2'b10, 0, 32'h010, 32'h8899AABC, 3, 0, 32'h00000000);
    tv[1]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h8899AABC);
    tv[2]  = mk(0, 2'b00, 1, 32'h013, 32'h0,        2, 0, 32'hFFFFFF88);
    tv[3]  = mk(0, 2'b00, 0, 32'h013, 32'h0,        2, 0, 32'h00000088);
    tv[4]  = mk(0, 2'b00, 1, 32'h010, 32'h0,        2, 0, 32'hFFFFFFBC);
    tv[5]  = mk(1, 2'b00, 0, 32'h011, 32'h12345655, 3, 0, 32'hFFFFFFBC);
    tv[6]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h889955BC);
    tv[7]  = mk(1, 2'b01, 0, 32'h012, 32'h00007777, 3, 0, 32'h889955BC);
    tv[8]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h777755BC);
    tv[9]  = mk(0, 2'b10, 0, 32'h012, 32'h0,        1, 1, 32'h777755BC);
    tv[10] = mk(1, 2'b01, 0, 32'h011, 32'hFFFFFFFF, 1, 1, 32'h777755BC);
    tv[11] = mk(0, 2'b11, 0, 32'h010, 32'h0,        1, 1, 32'h777755BC);
    tv[12] = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h777755BC);
    tv[13] = mk(0, 2'b01, 0, 32'h012, 32'h0,        2, 0, 32'h00007777);
    tv[14] = mk(0, 2'b01, 1, 32'h010, 32'h0,        2, 0, 32'h000055BC);
    tv[15] = mk(1, 2'b01, 0, 32'h410, 32'hFFFF8001, 3, 0, 32'h000055BC);
    tv[16] = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h77778001);
    tv[17] = mk(0, 2'b01, 1, 32'h410, 32'h0,        2, 0, 32'hFFFF8001);
    tv[18] = mk(0, 2'b00, 0, 32'h011, 32'h0,        2, 0, 32'h00000080);
    tv[19] = mk(1, 2'b00, 0, 32'h3FF, 32'h000000AB, 3, 0, 32'h00000080);
    tv[20] = mk(0, 2'b10, 0, 32'h3FC, 32'h0,        2, 0, 32'hAB000000);
    tv[21] = mk(0, 2'b00, 1, 32'h7FF, 32'h0,        2, 0, 32'hFFFFFFAB);
    tv[22] = mk(1, 2'b10, 0, 32'h013, 32'h11111111, 1, 1, 32'hFFFFFFAB);
    tv[23] = mk(0, 2'b10, 0, 32'h010, 32'h0,        2, 0, 32'h77778001);
    tv[24] = mk(0, 2'b01, 1, 32'h3FE, 32'h0,        2, 0, 32'hFFFFAB00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset dm_we", 32'(dm_we), 32'd0);
    chk("reset dm_addr", 32'(dm_addr), 32'd0);
    chk("reset dm_din", dm_din, 32'd0);
    rst = 1'b0;
    mem_clr = 1'b0;

    for (int i = 0; i < 25; i++) run_chk($sformatf("v%0d", i), tv[i]);

    // req held high: lw @0x410 accepted every third cycle
    @(negedge clk);
    drive(mk(0, 2'b10, 0, 32'h410, 32'h0, 2, 0, 32'h0));
    req = 1'b1;
    dcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("held c%0d busy", c), 32'(busy), (c % 3 != 0) ? 32'd1 : 32'd0);
      chk($sformatf("held c%0d done", c), 32'(done), (c % 3 == 2) ? 32'd1 : 32'd0);
      if (done) dcnt++;
    end
    req = 1'b0;
    chk("held done count", 32'(dcnt), 32'd3);
    chk("held rdata", rdata, 32'h77778001);
    @(negedge clk);
    chk("held idle after drop", 32'(busy), 32'd0);

    // reset during RD of a store
    @(negedge clk);
    drive(mk(1, 2'b10, 0, 32'h020, 32'hDEADBEEF, 3, 0, 32'h0));
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("rd busy before rst", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst busy async", 32'(busy), 32'd0);
    chk("rst done async", 32'(done), 32'd0);
    chk("rst dm_we async", 32'(dm_we), 32'd0);
    @(negedge clk);
    chk("rst rdata", rdata, 32'd0);
    rst = 1'b0;
    run_chk("post-rst lw 0x010", mk(0, 2'b10, 0, 32'h010, 32'h0, 2, 0, 32'h77778001));
    run_chk("abandoned sw 0x020", mk(0, 2'b10, 0, 32'h020, 32'h0, 2, 0, 32'h00000000));

    // reset during WR drops dm_we immediately
    @(negedge clk);
    drive(mk(1, 2'b10, 0, 32'h030, 32'h12345678, 3, 0, 32'h0));
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1;
    chk("wr dm_we before rst", 32'(dm_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("wr rst dm_we async", 32'(dm_we), 32'd0);
    chk("wr rst busy async", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_chk("post-wr-rst lw 0x010", mk(0, 2'b10, 0, 32'h010, 32'h0, 2, 0, 32'h77778001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
